// File: rtl/qproc_tdisp_pkg.sv
// Shared types for the timed-event dispatcher: time width, FSM states and the queued event record.
// Event records carry EVT_DW payload bits; the dispatcher's DW must not exceed EVT_DW.
package qproc_tdisp_pkg;

    localparam int TIME_W = 48;
    localparam int EVT_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] ts;
        logic [EVT_DW-1:0] data;
    } evt_t;

endpackage

// File: rtl/qproc_tdisp_fifo.sv
// First-word-fall-through event FIFO with synchronous clear and registered count/empty/full.
module qproc_tdisp_fifo
    import qproc_tdisp_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = evt_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  entry_t                 wdata_i,
    input  logic                   pop_i,
    output entry_t                 rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty_q, full_q;
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers are updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == '0);
            full_q   <= (cnt_d == FULL_CNT);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/qproc_time_dispatch.sv
// Timed-event dispatcher: releases queued payloads as one-cycle strobes when the absolute time reaches their timestamp.
// Build option QPROC_TDISP_LATE_DROP_EN: late heads are popped and discarded instead of dispatched.
module qproc_time_dispatch
    import qproc_tdisp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                   t_clk_i,
    input  logic                   t_rst_ni,
    input  logic [TIME_W-1:0]      time_abs_i,
    input  logic                   time_rst_i,
    input  logic                   flush_i,
    input  logic                   push_vld_i,
    output logic                   push_rdy_o,
    input  logic [TIME_W-1:0]      push_time_i,
    input  logic [DW-1:0]          push_data_i,
    output logic                   out_vld_o,
    output logic [DW-1:0]          out_data_o,
    output logic                   late_o,
    output logic [$clog2(DEPTH):0] cnt_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    evt_t              push_evt, head_evt;
    logic              clr, fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_cnt;
    logic [TIME_W-1:0] diff;
    logic              due, exact, late_now, emit;

    state_t            state_q;
    logic              out_vld_q, late_q;
    logic [DW-1:0]     out_data_q;

    assign clr        = flush_i | time_rst_i;
    assign push_rdy_o = ~fifo_full & (state_q != ST_FLUSH);
    assign fifo_push  = push_vld_i & push_rdy_o & ~clr;

    assign push_evt.ts   = push_time_i;
    assign push_evt.data = EVT_DW'(push_data_i);

    qproc_tdisp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (evt_t)
    ) u_fifo (
        .clk_i   (t_clk_i),
        .rst_ni  (t_rst_ni),
        .clr_i   (clr),
        .push_i  (fifo_push),
        .wdata_i (push_evt),
        .pop_i   (fifo_pop),
        .rdata_o (head_evt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .cnt_o   (fifo_cnt)
    );

    // Signed modulo-2^48 difference keeps the due test correct across counter wrap.
    assign diff     = time_abs_i - head_evt.ts;
    assign due      = ~diff[TIME_W-1];
    assign exact    = (diff == '0);
    assign late_now = due & ~exact;
    assign fifo_pop = (state_q == ST_ARM) & ~fifo_empty & due & ~clr;

`ifdef QPROC_TDISP_LATE_DROP_EN
    assign emit = fifo_pop & exact;
`else
    assign emit = fifo_pop;
`endif

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state_q    <= ST_IDLE;
            out_vld_q  <= 1'b0;
            late_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q <= 1'b0;
            late_q    <= 1'b0;
            if (clr) begin
                state_q <= ST_FLUSH;
            end else begin
                case (state_q)
                    ST_IDLE:  if (fifo_push) state_q <= ST_ARM;
                    ST_ARM: begin
                        if (fifo_empty || (fifo_pop && fifo_cnt == CW'(1) && !fifo_push))
                            state_q <= ST_IDLE;
                    end
                    ST_FLUSH: state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
            if (fifo_pop) late_q <= late_now;
            if (emit) begin
                out_vld_q  <= 1'b1;
                out_data_q <= DW'(head_evt.data);
            end
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_data_o = out_data_q;
    assign late_o     = late_q;
    assign cnt_o      = fifo_cnt;
    assign empty_o    = fifo_empty;
    assign full_o     = fifo_full;

endmodule
